// File: rtl/pipelined_addsub.sv
// N-bit add/subtract unit split into STAGES carry-chained W-bit slices, one slice per
// pipeline stage, with a valid/ready handshake on both sides and carry/overflow flags.
module pipelined_addsub #(
  parameter int N      = 32,
  parameter int STAGES = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] Sum,
  output logic         Cout,
  output logic         Ovf
);

  localparam int W = N / STAGES;
  localparam int L = STAGES - 1;

  function automatic logic [W:0] slice_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic c);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
  endfunction

  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  logic         en;
  logic [N-1:0] beff_in;
  logic         c0;

  assign beff_in = sub ? ~B : B;
  assign c0      = sub ? ~Cin : Cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int LO = k * W;
    localparam int BW = N - LO;

    logic [N-1:0]  x_src;
    logic [BW-1:0] b_src;
    logic          c_src;
    logic          v_src;
    logic [W:0]    slice;
    logic [N-1:0]  x_nxt;
    logic [N-1:0]  x_p;
    logic          cy_p;
    logic          vld_p;

    // Stage k: x_p holds finished sum slices 0..k below the A slices still to be added
    if (k == 0) begin : g_head
      assign x_src = A;
      assign b_src = beff_in;
      assign c_src = c0;
      assign v_src = in_valid && en;
    end else begin : g_link
      assign x_src = g_st[k-1].x_p;
      assign b_src = g_st[k-1].g_dly.beff_p;
      assign c_src = g_st[k-1].cy_p;
      assign v_src = g_st[k-1].vld_p;
    end

    assign slice = slice_add(x_src[LO +: W], b_src[W-1:0], c_src);

    always_comb begin
      x_nxt          = x_src;
      x_nxt[LO +: W] = slice[W-1:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        vld_p <= 1'b0;
        x_p   <= '0;
        cy_p  <= 1'b0;
      end else if (en) begin
        vld_p <= v_src;
        x_p   <= x_nxt;
        cy_p  <= slice[W];
      end
    end

    if (k < L) begin : g_dly
      logic [BW-W-1:0] beff_p;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          beff_p <= '0;
        end else if (en) begin
          beff_p <= b_src[BW-1:W];
        end
      end
    end else begin : g_tail
      logic ovf_p;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          ovf_p <= 1'b0;
        end else if (en) begin
          ovf_p <= signed_ovf(x_src[N-1], b_src[BW-1], slice[W-1]);
        end
      end
    end
  end

  assign en        = !g_st[L].vld_p || out_ready;
  assign in_ready  = en;
  assign out_valid = g_st[L].vld_p;
  assign Sum       = g_st[L].x_p;
  assign Cout      = g_st[L].cy_p;
  assign Ovf       = g_st[L].g_tail.ovf_p;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: a 32-bit/4-stage and an 8-bit/2-stage instance checked
// against an arithmetic reference model and a handful of literal expectations.
module tb_pipelined_addsub;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iv[2], ordy[2], cin[2], sb[2];
  logic [31:0] ia[2], ib[2];

  logic        ir32, ov32, co32, of32;
  logic [31:0] s32;
  logic        ir8, ov8, co8, of8;
  logic [7:0]  s8;

  int tests = 0;
  int fails = 0;

  logic [33:0] sbuf[2][64];
  int          hd[2], tl[2], dcnt[2];
  bit          pst[2];
  logic [33:0] pout[2];
  bit          pat[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  bit          ovs[12];

  always #5 clk = ~clk;

  pipelined_addsub #(.N(32), .STAGES(4)) u32 (
    .clk(clk), .reset_n(rst_n), .in_valid(iv[0]), .in_ready(ir32),
    .A(ia[0]), .B(ib[0]), .Cin(cin[0]), .sub(sb[0]),
    .out_valid(ov32), .out_ready(ordy[0]), .Sum(s32), .Cout(co32), .Ovf(of32));

  pipelined_addsub #(.N(8), .STAGES(2)) u8 (
    .clk(clk), .reset_n(rst_n), .in_valid(iv[1]), .in_ready(ir8),
    .A(ia[1][7:0]), .B(ib[1][7:0]), .Cin(cin[1]), .sub(sb[1]),
    .out_valid(ov8), .out_ready(ordy[1]), .Sum(s8), .Cout(co8), .Ovf(of8));

  function automatic int nw(int d);
    return (d == 0) ? 32 : 8;
  endfunction

  function automatic int lat(int d);
    return (d == 0) ? 4 : 2;
  endfunction

  // {in_ready, out_valid, Ovf, Cout, Sum}
  function automatic logic [35:0] outs(int d);
    if (d == 0) return {ir32, ov32, of32, co32, s32};
    return {ir8, ov8, of8, co8, 24'd0, s8};
  endfunction

  // Reference: {Ovf, Cout, Sum} of an n-bit add or subtract, by plain arithmetic.
  function automatic logic [33:0] model(int n, logic [31:0] a, logic [31:0] b, logic c, logic s);
    logic [32:0] m, r;
    logic [31:0] mask, am, be, sum;
    logic        c_in, cout, ovf;
    m    = (33'h1 << n) - 33'h1;
    mask = m[31:0];
    am   = a & mask;
    be   = s ? (~b & mask) : (b & mask);
    c_in = s ? ~c : c;
    r    = {1'b0, am} + {1'b0, be} + {32'd0, c_in};
    sum  = r[31:0] & mask;
    cout = r[n];
    ovf  = (am[n-1] == be[n-1]) && (sum[n-1] != am[n-1]);
    return {ovf, cout, sum};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      4:       return 32'h0000_0080;
      5:       return 32'h0000_007F;
      default: return $urandom;
    endcase
  endfunction

  task automatic check(input string nm, input logic [35:0] act, input logic [35:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [35:0] o;
    logic [33:0] e;
    for (int d = 0; d < 2; d++) begin
      o = outs(d);
      if (!rst_n) begin
        hd[d]  = 0;
        tl[d]  = 0;
        pst[d] = 1'b0;
        check($sformatf("d%0d_reset_clear", d), {1'b0, o[34:0]}, 36'd0);
      end else begin
        check($sformatf("d%0d_in_ready", d), {35'd0, o[35]}, {35'd0, (!o[34] || ordy[d])});
        if (pst[d]) check($sformatf("d%0d_stall_hold", d), {1'b0, o[34:0]}, {2'b01, pout[d]});
        if (o[34] && ordy[d]) begin
          if (hd[d] == tl[d]) begin
            tests++;
            fails++;
            $display("FAIL d%0d_unexpected_out: got %h, expected no output", d, o[33:0]);
          end else begin
            e = sbuf[d][hd[d] % 64];
            hd[d]++;
            dcnt[d]++;
            check($sformatf("d%0d_result", d), {2'b00, o[33:0]}, {2'b00, e});
          end
        end
        if (iv[d] && o[35]) begin
          sbuf[d][tl[d] % 64] = model(nw(d), ia[d], ib[d], cin[d], sb[d]);
          tl[d]++;
        end
        pst[d]  = o[34] && !ordy[d];
        pout[d] = o[33:0];
      end
    end
  end

  task automatic issue(input int d, input logic [31:0] a, input logic [31:0] b,
                       input logic c, input logic s);
    int k = 0;
    logic [35:0] o;
    ia[d] = a; ib[d] = b; cin[d] = c; sb[d] = s; iv[d] = 1'b1;
    #1;
    o = outs(d);
    while (!o[35] && k < 100) begin
      @(posedge clk); #1;
      o = outs(d);
      k++;
    end
    if (k >= 100) begin
      tests++;
      fails++;
      $display("FAIL d%0d_issue_timeout: in_ready stayed 0 for %0d cycles, expected 1", d, k);
    end
    @(posedge clk); #1;
    iv[d] = 1'b0;
  endtask

  task automatic wait_out(input int d, input string nm, input logic [33:0] exp);
    int cnt = 1;
    logic [35:0] o;
    o = outs(d);
    while (!o[34] && cnt < 64) begin
      @(posedge clk); #1;
      cnt++;
      o = outs(d);
    end
    check({nm, "_valid"}, {35'd0, o[34]}, 36'd1);
    check({nm, "_latency"}, 36'(cnt), 36'(lat(d)));
    check(nm, {2'b00, o[33:0]}, {2'b00, exp});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1);
  end

  initial begin
    int i, base, pre;
    bit acc;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      iv[d] = 1'b0; ordy[d] = 1'b1; ia[d] = '0; ib[d] = '0; cin[d] = 1'b0; sb[d] = 1'b0;
      dcnt[d] = 0;
    end

    check("model_pin_add", {2'b00, model(32, 32'h0000_FFFF, 32'h1, 1'b0, 1'b0)}, 36'h0_0001_0000);
    check("model_pin_sub", {2'b00, model(8, 32'h80, 32'h01, 1'b0, 1'b1)}, {2'b00, 2'b11, 32'h7F});
    check("model_pin_brw", {2'b00, model(8, 32'h05, 32'h07, 1'b1, 1'b1)}, {2'b00, 2'b00, 32'hFD});

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("reset_in_ready", {34'd0, ir32, ir8}, 36'd3);
    check("reset_outputs", {1'b0, ov32, of32, co32, s32}, 36'd0);

    issue(0, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    wait_out(0, "carry_slice", {2'b00, 32'h0001_0000});
    issue(0, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
    wait_out(0, "full_ripple", {2'b01, 32'h0});
    issue(1, 32'h80, 32'h01, 1'b0, 1'b1);
    wait_out(1, "sub_ovf", {2'b11, 32'h7F});
    issue(1, 32'h05, 32'h07, 1'b1, 1'b1);
    wait_out(1, "sub_borrow", {2'b00, 32'hFD});
    repeat (6) @(posedge clk);
    #1;

    for (int c = 0; c < 12; c++) begin
      ovs[c] = ov32;
      iv[0]  = (c < 4) ? pat[c] : 1'b0;
      ia[0]  = $urandom;
      ib[0]  = $urandom;
      @(posedge clk); #1;
    end
    for (int c = 0; c < 4; c++) begin
      check($sformatf("bubble_lead_%0d", c), {35'd0, ovs[c]}, 36'd0);
      check($sformatf("bubble_out_%0d", c), {35'd0, ovs[c+4]}, {35'd0, pat[c]});
    end

    base = dcnt[0];
    i = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      ordy[0] = !(cyc >= 6 && cyc <= 9);
      if (i < 10) begin
        iv[0] = 1'b1; ia[0] = i; ib[0] = i; cin[0] = 1'b0; sb[0] = 1'b0;
      end else begin
        iv[0] = 1'b0;
      end
      #1;
      if (cyc >= 6 && cyc <= 9) check($sformatf("stall_in_ready_%0d", cyc), {35'd0, ir32}, 36'd0);
      acc = iv[0] && ir32;
      @(posedge clk); #1;
      if (acc) i++;
    end
    ordy[0] = 1'b1;
    check("bp_accepted", 36'(i), 36'd10);
    check("bp_delivered", 36'(dcnt[0] - base), 36'd10);

    for (int j = 0; j < 3; j++) begin
      iv[0] = 1'b1; ia[0] = j + 1; ib[0] = j; cin[0] = 1'b0; sb[0] = 1'b0;
      @(posedge clk); #1;
    end
    iv[0] = 1'b0;
    pre = dcnt[0];
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int j = 0; j < 8; j++) begin
      check($sformatf("flush_no_out_%0d", j), {35'd0, ov32}, 36'd0);
      @(posedge clk); #1;
    end
    check("flush_no_delivery", 36'(dcnt[0] - pre), 36'd0);
    issue(0, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    wait_out(0, "after_reset", {2'b00, 32'h2345_6789});

    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int d = 0; d < 2; d++) begin
        iv[d]   = ($urandom_range(0, 9) < 6);
        ia[d]   = pick();
        ib[d]   = pick();
        cin[d]  = 1'($urandom);
        sb[d]   = 1'($urandom);
        ordy[d] = ($urandom_range(0, 3) != 0);
      end
      @(posedge clk); #1;
    end
    for (int d = 0; d < 2; d++) begin
      iv[d] = 1'b0;
      ordy[d] = 1'b1;
    end
    repeat (12) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d_drain_empty", d), 36'(tl[d] - hd[d]), 36'd0);
      check($sformatf("d%0d_drain_idle", d), {35'd0, outs(d) == 36'h0 ? 1'b0 : outs(d) >> 34 == 36'd2}, 36'd1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
